// File: rtl/ncl_add_sched.sv
// Clocked scheduler that arbitrates two requesters onto one dual-rail NCL adder.
// Optional build macro NCL_SCHED_TIMEOUT_EN adds a bounded wait on every adder wavefront.
module ncl_add_sched #(
    parameter int W   = 8,
    parameter int TMO = 255
) (
    input  logic           clk,
    input  logic           init,
    input  logic           req0,
    input  logic           req1,
    input  logic [W-1:0]   a0,
    input  logic [W-1:0]   b0,
    input  logic [W-1:0]   a1,
    input  logic [W-1:0]   b1,
    input  logic           cin0,
    input  logic           cin1,
    output logic           done0,
    output logic           done1,
    output logic [W-1:0]   sum,
    output logic           cout,
    output logic [2*W-1:0] a_dr,
    output logic [2*W-1:0] b_dr,
    output logic [1:0]     cin_dr,
    input  logic [2*W-1:0] sum_dr,
    input  logic [1:0]     cout_dr,
    output logic           res_comp,
    output logic           err,
    output logic           tmo
);

    localparam int RW = 2 * W + 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DATA = 3'd1,
        CAPT = 3'd2,
        NUL  = 3'd3,
        WNUL = 3'd4
    } state_t;

    function automatic logic [2*W-1:0] dr_enc(input logic [W-1:0] v);
        logic [2*W-1:0] r;
        r = {(2*W){1'b0}};
        for (int i = 0; i < W; i++) begin
            r[2*i +: 2] = {v[i], ~v[i]};
        end
        return r;
    endfunction

    state_t         state_r, state_n;
    logic           gnt_r, gnt_n;
    logic [RW-1:0]  sync1_r, sync2_r;
    logic           complete_s, null_s, illegal_s;
    logic [W-1:0]   sum_dec_s;
    logic           cout_dec_s;
    logic           go_s, cap_s, zero_s, rc_n, err_set_s;
    logic [2*W-1:0] a_dr_r, b_dr_r;
    logic [1:0]     cin_dr_r;
    logic           rc_r, done0_r, done1_r, cout_r, err_r;
    logic [W-1:0]   sum_r;

    // Two-flop synchronizer on every adder result rail
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            sync1_r <= {RW{1'b0}};
            sync2_r <= {RW{1'b0}};
        end else begin
            sync1_r <= {cout_dr, sum_dr};
            sync2_r <= sync1_r;
        end
    end

    // Completion, null and illegal-code detection plus rail1 decode
    always_comb begin
        complete_s = 1'b1;
        illegal_s  = 1'b0;
        sum_dec_s  = {W{1'b0}};
        for (int i = 0; i < W + 1; i++) begin
            complete_s = complete_s & (sync2_r[2*i +: 2] == 2'b01 || sync2_r[2*i +: 2] == 2'b10);
            illegal_s  = illegal_s | (sync2_r[2*i +: 2] == 2'b11);
        end
        for (int i = 0; i < W; i++) begin
            sum_dec_s[i] = sync2_r[2*i+1];
        end
        cout_dec_s = sync2_r[2*W+1];
        null_s     = (sync2_r == {RW{1'b0}});
    end

`ifdef NCL_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0] cnt_r;
    logic          tmo_r, tmo_set_s, tmo_hit_s;

    assign tmo_hit_s = (cnt_r == CW'(TMO - 1));
`endif

    // State register; gnt_r remembers the last grant and starts at 1 so requester 0 wins first
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_r <= IDLE;
            gnt_r   <= 1'b1;
        end else begin
            state_r <= state_n;
            gnt_r   <= gnt_n;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_n   = state_r;
        gnt_n     = gnt_r;
        go_s      = 1'b0;
        cap_s     = 1'b0;
        zero_s    = 1'b0;
        rc_n      = rc_r;
        err_set_s = 1'b0;
`ifdef NCL_SCHED_TIMEOUT_EN
        tmo_set_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                rc_n = 1'b1;
                if ((req0 || req1) && null_s) begin
                    go_s    = 1'b1;
                    state_n = DATA;
                    if (req0 && req1) begin
                        gnt_n = ~gnt_r;
                    end else begin
                        gnt_n = req1;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            DATA: begin
                err_set_s = illegal_s;
                if (complete_s) begin
                    state_n = CAPT;
`ifdef NCL_SCHED_TIMEOUT_EN
                end else if (tmo_hit_s) begin
                    tmo_set_s = 1'b1;
                    zero_s    = 1'b1;
                    rc_n      = 1'b0;
                    state_n   = NUL;
`endif
                end else begin
                    state_n = DATA;
                end
            end
            CAPT: begin
                cap_s   = 1'b1;
                zero_s  = 1'b1;
                rc_n    = 1'b0;
                state_n = NUL;
            end
            NUL: begin
                rc_n    = 1'b0;
                state_n = WNUL;
            end
            WNUL: begin
                err_set_s = illegal_s;
                if (null_s) begin
                    rc_n    = 1'b1;
                    state_n = IDLE;
`ifdef NCL_SCHED_TIMEOUT_EN
                end else if (tmo_hit_s) begin
                    tmo_set_s = 1'b1;
                    rc_n      = 1'b1;
                    state_n   = IDLE;
`endif
                end else begin
                    state_n = WNUL;
                end
            end
            default: begin
                rc_n    = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    // Registered outputs; operand rails only move on grant and on the return-to-null step
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            a_dr_r   <= {(2*W){1'b0}};
            b_dr_r   <= {(2*W){1'b0}};
            cin_dr_r <= 2'b00;
            rc_r     <= 1'b1;
            done0_r  <= 1'b0;
            done1_r  <= 1'b0;
            sum_r    <= {W{1'b0}};
            cout_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            if (go_s) begin
                a_dr_r   <= dr_enc(gnt_n ? a1 : a0);
                b_dr_r   <= dr_enc(gnt_n ? b1 : b0);
                cin_dr_r <= gnt_n ? {cin1, ~cin1} : {cin0, ~cin0};
            end else if (zero_s) begin
                a_dr_r   <= {(2*W){1'b0}};
                b_dr_r   <= {(2*W){1'b0}};
                cin_dr_r <= 2'b00;
            end else begin
                a_dr_r   <= a_dr_r;
                b_dr_r   <= b_dr_r;
                cin_dr_r <= cin_dr_r;
            end
            if (cap_s) begin
                sum_r  <= sum_dec_s;
                cout_r <= cout_dec_s;
            end else begin
                sum_r  <= sum_r;
                cout_r <= cout_r;
            end
            rc_r    <= rc_n;
            done0_r <= cap_s & ~gnt_r;
            done1_r <= cap_s & gnt_r;
            err_r   <= err_r | err_set_s;
        end
    end

`ifdef NCL_SCHED_TIMEOUT_EN
    // Wavefront wait counter, restarted on every state change
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            cnt_r <= {CW{1'b0}};
            tmo_r <= 1'b0;
        end else begin
            if (state_n != state_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (state_r == DATA || state_r == WNUL) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (tmo_set_s) begin
                tmo_r <= 1'b1;
            end else begin
                tmo_r <= tmo_r;
            end
        end
    end

    assign tmo = tmo_r;
`else
    assign tmo = 1'b0;
`endif

    assign a_dr     = a_dr_r;
    assign b_dr     = b_dr_r;
    assign cin_dr   = cin_dr_r;
    assign res_comp = rc_r;
    assign done0    = done0_r;
    assign done1    = done1_r;
    assign sum      = sum_r;
    assign cout     = cout_r;
    assign err      = err_r;

endmodule

// File: tb/tb_ncl_add_sched.sv
// Directed bench for ncl_add_sched with a behavioural 10-cycle dual-rail adder and a
// scoreboard of expected sums; the timeout scenario is built only with NCL_SCHED_TIMEOUT_EN.
module tb_ncl_add_sched;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           init = 1'b1;
    logic           req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic           cin0 = 1'b0, cin1 = 1'b0;
    logic           done0, done1, cout, res_comp, err, tmo;
    logic [W-1:0]   sum;
    logic [2*W-1:0] a_dr, b_dr, sum_dr;
    logic [1:0]     cin_dr, cout_dr;

    always #5 clk = ~clk;

    ncl_add_sched #(.W(W), .TMO(20)) dut (
        .clk(clk), .init(init), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .cin0(cin0), .cin1(cin1),
        .done0(done0), .done1(done1), .sum(sum), .cout(cout),
        .a_dr(a_dr), .b_dr(b_dr), .cin_dr(cin_dr),
        .sum_dr(sum_dr), .cout_dr(cout_dr),
        .res_comp(res_comp), .err(err), .tmo(tmo)
    );

    int tests = 0;
    int fails = 0;
    logic mode_err = 1'b0;
    logic mode_never = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic legal_dr(input logic [2*W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < W; i++) begin
            ok = ok & (v[2*i +: 2] == 2'b01 || v[2*i +: 2] == 2'b10);
        end
        return ok;
    endfunction

    // Behavioural NCL adder: DATA out when inputs are complete and DATA is requested,
    // NULL out when inputs are null and NULL is requested, 10 cycles after the change.
    logic [2*W+1:0] ad_out;
    int             ad_cnt;

    function automatic logic [2*W+1:0] ad_tgt(input logic [2*W-1:0] ar, input logic [2*W-1:0] br,
                                              input logic [1:0] cr, input logic rc,
                                              input logic [2*W+1:0] cur);
        logic [W-1:0]   av, bv;
        logic [W:0]     s;
        logic [2*W+1:0] t;
        logic           full, empty;
        full  = (cr == 2'b01 || cr == 2'b10) && legal_dr(ar) && legal_dr(br);
        empty = (ar == '0) && (br == '0) && (cr == 2'b00);
        for (int i = 0; i < W; i++) begin
            av[i] = ar[2*i+1];
            bv[i] = br[2*i+1];
        end
        if (full && rc && !mode_never) begin
            s = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cr[1]};
            for (int i = 0; i <= W; i++) t[2*i +: 2] = s[i] ? 2'b10 : 2'b01;
            if (mode_err) t[1:0] = 2'b11;
            return t;
        end else if (empty && !rc) begin
            return '0;
        end else begin
            return cur;
        end
    endfunction

    always @(posedge clk or posedge init) begin
        if (init) begin
            ad_out <= '0;
            ad_cnt <= 0;
        end else if (ad_tgt(a_dr, b_dr, cin_dr, res_comp, ad_out) != ad_out) begin
            if (ad_cnt == 9) begin
                ad_out <= ad_tgt(a_dr, b_dr, cin_dr, res_comp, ad_out);
                ad_cnt <= 0;
            end else begin
                ad_cnt <= ad_cnt + 1;
            end
        end else begin
            ad_cnt <= 0;
        end
    end

    assign sum_dr  = ad_out[2*W-1:0];
    assign cout_dr = ad_out[2*W+1:2*W];

    // Scoreboard of expected completions in order
    typedef struct {
        int         id;
        logic [7:0] s;
        logic       c;
    } exp_t;
    exp_t q[$];

    task automatic push_exp(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t e;
        logic [W:0] r;
        r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.id = id;
        e.s  = r[W-1:0];
        e.c  = r[W];
        q.push_back(e);
    endtask

    // Per-cycle compare against the scoreboard
    initial begin
        exp_t           e;
        logic [W-1:0]   held_sum;
        logic           held_cout, prev_done, rails_ok;
        logic [2*W-1:0] prev_a;
        held_sum = '0; held_cout = 1'b0; prev_done = 1'b0; prev_a = '0;
        forever begin
            @(negedge clk);
            if (init) begin
                held_sum = '0; held_cout = 1'b0; prev_done = 1'b0; prev_a = '0;
            end else begin
                if (done0 || done1) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_done: got done0=%b done1=%b expected none at %0t", done0, done1, $time);
                    end else begin
                        e = q.pop_front();
                        check("done_id", {30'd0, done1, done0}, (e.id == 1) ? 32'd2 : 32'd1);
                        check("done_sum", {23'd0, cout, sum}, {23'd0, e.c, e.s});
                        held_sum = e.s;
                        held_cout = e.c;
                    end
                    check("done_single", {31'd0, prev_done}, 32'd0);
                end else begin
                    check("sum_hold", {23'd0, cout, sum}, {23'd0, held_cout, held_sum});
                end
                rails_ok = (a_dr == prev_a) || (a_dr == '0) || (prev_a == '0 && legal_dr(a_dr));
                check("rails_monotonic", {31'd0, rails_ok}, 32'd1);
                if (!mode_err) check("err_clear", {31'd0, err}, 32'd0);
                prev_a = a_dr;
                prev_done = done0 | done1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int id);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((id == 0 && done0) || (id == 1 && done1)) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_done", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_data();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_dr != '0) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_data", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        // Reset state
        check("rst_a_dr", {16'd0, a_dr}, 32'd0);
        check("rst_b_dr", {16'd0, b_dr}, 32'd0);
        check("rst_cin_dr", {30'd0, cin_dr}, 32'd0);
        check("rst_res_comp", {31'd0, res_comp}, 32'd1);
        check("rst_done", {30'd0, done1, done0}, 32'd0);
        check("rst_sum", {23'd0, cout, sum}, 32'd0);
        check("rst_flags", {30'd0, err, tmo}, 32'd0);
        init = 1'b0;
        tick(2);

        // Single transaction from requester 0
        a0 = 8'h5A; b0 = 8'h33; cin0 = 1'b0;
        push_exp(0, a0, b0, cin0);
        req0 = 1'b1;
        wait_done(0);
        req0 = 1'b0;
        check("t1_sum", {23'd0, cout, sum}, 32'h08D);
        tick(20);
        check("t1_a_dr_null", {16'd0, a_dr}, 32'd0);
        check("t1_res_comp", {31'd0, res_comp}, 32'd1);

        // Both requests held: grants alternate starting with requester 0 after reset
        init = 1'b1;
        tick(2);
        init = 1'b0;
        tick(2);
        a0 = 8'hFF; b0 = 8'h01; cin0 = 1'b0;
        a1 = 8'h10; b1 = 8'h20; cin1 = 1'b1;
        for (int k = 0; k < 4; k++) push_exp(k % 2, (k % 2) ? a1 : a0, (k % 2) ? b1 : b0, (k % 2) ? cin1 : cin0);
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_done(k % 2);
            if (k == 0) check("t2_first", {23'd0, cout, sum}, 32'h100);
        end
        req0 = 1'b0; req1 = 1'b0;
        check("t2_last", {23'd0, cout, sum}, 32'h031);
        tick(20);

        // Request dropped during DATA still completes
        a1 = 8'h7F; b1 = 8'h01; cin1 = 1'b0;
        push_exp(1, a1, b1, cin1);
        req1 = 1'b1;
        wait_data();
        tick(2);
        req1 = 1'b0;
        wait_done(1);
        check("t3_sum", {23'd0, cout, sum}, 32'h080);
        tick(20);

        // init during DATA abandons the transaction
        a0 = 8'h12; b0 = 8'h34; cin0 = 1'b1;
        req0 = 1'b1;
        wait_data();
        tick(3);
        init = 1'b1;
        tick(1);
        check("t4_rails", {a_dr, b_dr[15:0]} == 32'd0 && cin_dr == 2'b00 ? 32'd1 : 32'd0, 32'd1);
        check("t4_sum", {23'd0, cout, sum}, 32'd0);
        req0 = 1'b0;
        init = 1'b0;
        tick(30);
        push_exp(0, a0, b0, cin0);
        req0 = 1'b1;
        wait_done(0);
        req0 = 1'b0;
        check("t4_next_sum", {23'd0, cout, sum}, 32'h047);
        tick(20);

        // Illegal 2'b11 pair from the adder sets a sticky err
        mode_err = 1'b1;
        a1 = 8'h01; b1 = 8'h02; cin1 = 1'b0;
        req1 = 1'b1;
        wait_data();
        tick(30);
        check("t5_err", {31'd0, err}, 32'd1);
        tick(10);
        check("t5_err_sticky", {31'd0, err}, 32'd1);
        init = 1'b1;
        tick(1);
        check("t5_err_cleared", {31'd0, err}, 32'd0);
        req1 = 1'b0;
        mode_err = 1'b0;
        init = 1'b0;
        tick(3);

`ifdef NCL_SCHED_TIMEOUT_EN
        // Adder never completes: timeout after 20 DATA cycles
        begin
            int n;
            mode_never = 1'b1;
            a0 = 8'h0F; b0 = 8'hF0; cin0 = 1'b0;
            req0 = 1'b1;
            wait_data();
            n = 1;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (tmo) break;
                n++;
            end
            check("t6_tmo_cycles", n, 32'd20);
            check("t6_tmo", {31'd0, tmo}, 32'd1);
            check("t6_rails", {16'd0, a_dr}, 32'd0);
            req0 = 1'b0;
            tick(30);
            mode_never = 1'b0;
            check("t6_tmo_sticky", {31'd0, tmo}, 32'd1);
        end
`endif

        check("queue_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
